count_tracker_8: RTL and testbench

Passive monitor on the output bus of an 8-bit up/down counter. Each clock it samples the counter value, infers count direction, and locks onto the sequence. It flags wrap-around, direction reversals and illegal steps, and keeps a saturating error tally. It sits beside the counter in the same clock domain and is the consumer of that counter's output.

---
 rtl/count_pkg.sv | 13 +
 rtl/count_tracker_8.sv | 120 ++++++++++++
 tb/tb_count_tracker_8.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/count_pkg.sv
// Shared types for the count_tracker monitor: tracking states and direction encoding.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  localparam logic UP = 1'b1;
  localparam logic DN = 1'b0;

endpackage

// File: rtl/count_tracker_8.sv
// Passive monitor for an up/down counter bus: locks onto the count sequence and
// reports wraps, direction reversals and illegal steps with a saturating tally.
module count_tracker_8
  import count_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             dir_out,
  output logic             wrap,
  output logic             dir_chg,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_V   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_V  = {WIDTH{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] up_s, dn_s, exp_s, rev_s;
  logic             dir_r, dir_nx_s;
  logic             locked_r, wrap_r, dir_chg_r, step_err_r;
  logic             wrap_nx_s, dir_chg_nx_s, step_err_nx_s;
  logic [ERR_W-1:0] err_r, err_nx_s;

  // Next-state, flag and error-tally decode from the current sample.
  always_comb begin
    up_s          = prev_r + ONE_V;
    dn_s          = prev_r - ONE_V;
    exp_s         = dir_r ? up_s : dn_s;
    rev_s         = dir_r ? dn_s : up_s;
    state_nx_s    = state_r;
    dir_nx_s      = dir_r;
    wrap_nx_s     = 1'b0;
    dir_chg_nx_s  = 1'b0;
    step_err_nx_s = 1'b0;

    case (state_r)
      IDLE: begin
        state_nx_s = ACQUIRE;
      end
      ACQUIRE: begin
        if (count_in == up_s) begin
          dir_nx_s   = UP;
          state_nx_s = TRACK;
        end else if (count_in == dn_s) begin
          dir_nx_s   = DN;
          state_nx_s = TRACK;
        end else begin
          state_nx_s = ACQUIRE;
        end
      end
      TRACK: begin
        if (count_in == exp_s) begin
          wrap_nx_s = dir_r ? (prev_r == MAX_V) : (prev_r == ZERO_V);
        end else if (count_in == rev_s) begin
          // A reversal steps the opposite way, so the crossing point flips too.
          dir_nx_s     = ~dir_r;
          dir_chg_nx_s = 1'b1;
          wrap_nx_s    = dir_r ? (prev_r == ZERO_V) : (prev_r == MAX_V);
        end else begin
          step_err_nx_s = 1'b1;
          state_nx_s    = ACQUIRE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    // Clear wins over the old value but the same-cycle error still counts.
    if (clr_err) begin
      err_nx_s = step_err_nx_s ? ERR_ONE : {ERR_W{1'b0}};
    end else if (step_err_nx_s && (err_r != ERR_MAX)) begin
      err_nx_s = err_r + ERR_ONE;
    end else begin
      err_nx_s = err_r;
    end
  end

  // State, last sample and registered flag outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      prev_r     <= ZERO_V;
      dir_r      <= UP;
      locked_r   <= 1'b0;
      wrap_r     <= 1'b0;
      dir_chg_r  <= 1'b0;
      step_err_r <= 1'b0;
      err_r      <= {ERR_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      prev_r     <= count_in;
      dir_r      <= dir_nx_s;
      locked_r   <= (state_nx_s == TRACK);
      wrap_r     <= wrap_nx_s;
      dir_chg_r  <= dir_chg_nx_s;
      step_err_r <= step_err_nx_s;
      err_r      <= err_nx_s;
    end
  end

  assign locked    = locked_r;
  assign dir_out   = dir_r;
  assign wrap      = wrap_r;
  assign dir_chg   = dir_chg_r;
  assign step_err  = step_err_r;
  assign err_count = err_r;

endmodule

// File: tb/tb_count_tracker_8.sv
// Table-driven bench for count_tracker_8 with a queue scoreboard of expected outputs.
module tb_count_tracker_8;

  typedef struct packed {
    logic [7:0] cin;
    logic       clr;
    logic       locked;
    logic       dir;
    logic       wrap;
    logic       chg;
    logic       serr;
    logic [7:0] cnt;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] count_in;
  logic       clr_err;
  logic       locked;
  logic       dir_out;
  logic       wrap;
  logic       dir_chg;
  logic       step_err;
  logic [7:0] err_count;

  int          errors;
  int          checks;
  vec_t        tbl[$];
  logic [12:0] sb[$];

  count_tracker_8 #(.WIDTH(8), .ERR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .clr_err  (clr_err),
    .locked   (locked),
    .dir_out  (dir_out),
    .wrap     (wrap),
    .dir_chg  (dir_chg),
    .step_err (step_err),
    .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  function automatic logic [12:0] observed();
    return {locked, dir_out, wrap, dir_chg, step_err, err_count};
  endfunction

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got locked=%b dir=%b wrap=%b chg=%b serr=%b cnt=%0d, want locked=%b dir=%b wrap=%b chg=%b serr=%b cnt=%0d",
               name, got[12], got[11], got[10], got[9], got[8], got[7:0],
               want[12], want[11], want[10], want[9], want[8], want[7:0]);
    end
  endtask

  task automatic add(input logic [7:0] c, input logic clr, input logic l, input logic d,
                     input logic w, input logic ch, input logic se, input logic [7:0] n);
    vec_t v;
    v = '{cin: c, clr: clr, locked: l, dir: d, wrap: w, chg: ch, serr: se, cnt: n};
    tbl.push_back(v);
  endtask

  // Drive one sample between edges, then compare the result of the following edge.
  task automatic step(input vec_t v, input string name);
    count_in = v.cin;
    clr_err  = v.clr;
    sb.push_back({v.locked, v.dir, v.wrap, v.chg, v.serr, v.cnt});
    @(posedge clk);
    #1;
    check(name, observed(), sb.pop_front());
    @(negedge clk);
  endtask

  task automatic step_args(input logic [7:0] c, input logic clr, input logic l, input logic d,
                           input logic w, input logic ch, input logic se, input logic [7:0] n,
                           input string name);
    vec_t v;
    v = '{cin: c, clr: clr, locked: l, dir: d, wrap: w, chg: ch, serr: se, cnt: n};
    step(v, name);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] sat;
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    count_in = 8'h00;
    clr_err  = 1'b0;

    //   cin    clr   lck   dir   wrap  chg   serr  cnt
    add(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    add(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    add(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    add(8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    add(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
    add(8'h0E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    add(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    add(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    add(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    add(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
    add(8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    add(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
    add(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
    add(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
    add(8'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4);
    add(8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    add(8'h27, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5);
    add(8'h28, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    add(8'h3F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd6);
    add(8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd6);
    add(8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7);
    add(8'h41, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

    #20;
    check("reset_state", observed(), 13'b0_1_0_0_0_00000000);
    #5;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Alternate hold (error) and +1 (re-lock) to drive the tally into saturation.
    v = 8'h41;
    for (int k = 1; k <= 260; k++) begin
      sat = (k > 255) ? 8'd255 : 8'(k);
      step_args(v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, sat, $sformatf("sat_err%0d", k));
      v = v + 8'd1;
      step_args(v, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, sat, $sformatf("sat_lock%0d", k));
    end

    step_args(v, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, "clr_with_err");
    v = v + 8'd1;
    step_args(v, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "clr_only");
    step_args(v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, "hold_err");
    v = v + 8'd1;
    step_args(v, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, "relock");

    // Asynchronous reset between edges, then two edges to re-lock.
    reset = 1'b1;
    #1;
    check("mid_reset", observed(), 13'b0_1_0_0_0_00000000);
    reset = 1'b0;
    step_args(8'h50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "post_reset_e0");
    step_args(8'h51, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "post_reset_e1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
